zf_equalizer_seq: RTL and testbench
===================================

# zf_equalizer_seq

Parametrised zero-forcing frequency-domain equalizer, and the successor to the fully parallel equalizer. It consumes one channel estimate per packet and computes per-bin reciprocals 1/|H|² with a single shared iterative divider instead of NFFT dividers. It then equalizes up to NSYM data symbols, one full symbol per cycle, as Y·conj(H)·(1/|H|²). It sits between the FFT/channel-estimation stage and the demapper.

## Interface
- NFFT, 64, bins per symbol
- IN_W, 22, signed input width (Y and H), IN_FRAC=15 fractional bits
- RF, 15, reciprocal fractional bits
- RECIP_W, 32, unsigned reciprocal width
- OUT_W, 32, signed output width, OUT_FRAC=26
- NSYM, 12, data symbols per channel estimate
- NULL_MASK, 64'h0000_003F_F800_0001, bit b=1 marks bin b as null (DC and guard bins)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- chan_re_i / chan_im_i  in  NFFT*IN_W  channel estimate; bin b at [(b+1)*IN_W-1 -: IN_W]
- chan_valid_i  in  1  capture estimate this cycle
- data_re_i / data_im_i  in  NFFT*IN_W  FFT'd data symbol, same packing
- data_valid_i  in  1  symbol present
- eq_ready_o  out  1  reciprocals valid; data accepted
- eq_re_o / eq_im_o  out  NFFT*OUT_W  equalized bins, Q(OUT_W-OUT_FRAC).OUT_FRAC
- eq_valid_o  out  NFFT  per-bin valid; always 0 on null bins
- eq_last_o  out  1  marks the NSYM-th symbol of a packet
- err_drop_o  out  1  one-cycle pulse: symbol dropped

## Operation
- FSM states: IDLE, DIVIDE, READY.
- **chan_valid_i in any state**
  - Capture H into the coefficient registers.
  - Clear the bin index and symbol counter.
  - Go to DIVIDE; a DIVIDE in progress is aborted and restarted.
- **DIVIDE, per bin b = 0..NFFT-1**
  - Cycle 1: register P = hr² + hi² (unsigned, 2·IN_W+1 bits, scale 2^30).
  - Next DIV_CYCLES = 2·IN_FRAC+RF+1 = 46 cycles: restoring division, one quotient bit per cycle.
  - Result is R = floor(2^(2·IN_FRAC+RF) / P), clamped to 2^RECIP_W−1.
  - P = 0 gives R = 2^RECIP_W−1.
  - R[b] is written at the end of bin b.
  - After the last bin, go to READY.
- **READY**
  - data_valid_i=1 accepts the symbol.
  - Stage 1 per non-null bin: Ar = yr·hr + yi·hi, Ai = yi·hr − yr·hi (scale 2^30).
  - Stage 2: E = (A·R[b]) >>> (2·IN_FRAC+RF−OUT_FRAC), an arithmetic shift (floor), then reduced to OUT_W bits.
  - The NSYM-th accepted symbol asserts eq_last_o on its output and sends the FSM to IDLE.
- **Dropped symbols:** data_valid_i while not READY is dropped. err_drop_o pulses the next cycle and no eq_valid_o is produced.
- **Null bins:** eq_valid_o bit stays 0 and the outputs are driven 0.
- **chan_valid_i and data_valid_i in the same READY cycle:** the symbol is accepted and equalized with the old H/R, then the FSM enters DIVIDE.
- **R regfile:** written only in DIVIDE, so symbols already in flight are unaffected.

## Timing
- **Reset values:** all outputs 0, FSM IDLE, counters 0, R regfile 0.
- **Reset mid-DIVIDE or mid-pipeline:** in-flight results are discarded with no output.
- **Estimate to ready:** chan_valid_i sampled at edge k → eq_ready_o high after edge k + 1 + NFFT·(DIV_CYCLES+1). That is 3009 cycles at the defaults.
- **eq_ready_o:** falls the cycle after chan_valid_i, or the cycle after the NSYM-th acceptance.
- **Equalization latency:** data accepted at edge k → eq_valid_o, eq_last_o and data valid after edge k+2.
- **Throughput:** one symbol per cycle, with back-to-back symbols allowed.
- **Output strobes:** eq_valid_o and eq_last_o are single-cycle per symbol.

## Configuration
- **ZFEQ_SAT_EN defined:** stage-2 results are saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- **ZFEQ_SAT_EN undefined:** the low OUT_W bits are kept, so results wrap.
- Reciprocal clamping is always present, regardless of the macro.

## Test plan
- **Unity channel:** H = 32768+0j on all bins, Y = 16384+0j → 3009 cycles after chan_valid_i, eq_ready_o=1. Then eq_re = 0x0200_0000 and eq_im = 0 on non-null bins, eq_valid_o = ~NULL_MASK, two cycles after data_valid_i.
- **Rotated channel:** H = 0+32768j, Y = 0+16384j → eq_re = 0x0200_0000, eq_im = 0.
- **Saturation:**
  - Input: bin 5 H = 1+0j, Y = 2097151+0j.
  - Expected R[5]: 0xFFFF_FFFF.
  - With ZFEQ_SAT_EN: eq_re bin 5 = 0x7FFF_FFFF.
  - Without ZFEQ_SAT_EN: the wrapped low 32 bits.
  - Bin with H = 0: no X/hang; R = 0xFFFF_FFFF.
- **Packet length:** NSYM=12, send 13 back-to-back symbols → 12 outputs, eq_last_o on the 12th, eq_ready_o low after the 12th acceptance, err_drop_o pulse for the 13th.
- **Abort and reset:**
  - chan_valid_i again mid-DIVIDE (cycle 1000) → ready arrives 3009 cycles after the second capture.
  - rst_i low mid-DIVIDE → all outputs 0 and eq_ready_o stays 0 until a new estimate completes.

Source files
------------

// File: rtl/zf_equalizer_seq.sv
// zf_equalizer_seq: zero-forcing equalizer with one shared iterative 1/|H|^2 divider.
// Define ZFEQ_SAT_EN to saturate equalized outputs instead of wrapping them.
module zf_equalizer_seq #(
  parameter int NFFT = 64,
  parameter int IN_W = 22,
  parameter int IN_FRAC = 15,
  parameter int RF = 15,
  parameter int RECIP_W = 32,
  parameter int OUT_W = 32,
  parameter int OUT_FRAC = 26,
  parameter int NSYM = 12,
  parameter logic [NFFT-1:0] NULL_MASK = 64'h0000_003F_F800_0001
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NFFT*IN_W-1:0]    chan_re_i,
  input  logic [NFFT*IN_W-1:0]    chan_im_i,
  input  logic                    chan_valid_i,
  input  logic [NFFT*IN_W-1:0]    data_re_i,
  input  logic [NFFT*IN_W-1:0]    data_im_i,
  input  logic                    data_valid_i,
  output logic                    eq_ready_o,
  output logic [NFFT*OUT_W-1:0]   eq_re_o,
  output logic [NFFT*OUT_W-1:0]   eq_im_o,
  output logic [NFFT-1:0]         eq_valid_o,
  output logic                    eq_last_o,
  output logic                    err_drop_o
);
  localparam int PW = 2*IN_W+1;
  localparam int AW = 2*IN_W+1;
  localparam int QW = 2*IN_FRAC+RF+1;
  localparam int MW = AW+RECIP_W+1;
  localparam int SH = 2*IN_FRAC+RF-OUT_FRAC;
  localparam int BW = $clog2(NFFT);
  localparam int CW = $clog2(QW+1);
  localparam int SW = $clog2(NSYM);
`ifdef ZFEQ_SAT_EN
  localparam logic signed [MW-1:0] SMAX = {{(MW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [MW-1:0] SMIN = {{(MW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, DIVIDE, READY} state_t;

  state_t                    state;
  logic signed [IN_W-1:0]    h_re [NFFT];
  logic signed [IN_W-1:0]    h_im [NFFT];
  logic [RECIP_W-1:0]        recip [NFFT];
  logic signed [AW-1:0]      a_re [NFFT];
  logic signed [AW-1:0]      a_im [NFFT];
  logic signed [MW-1:0]      m_re [NFFT];
  logic signed [MW-1:0]      m_im [NFFT];
  logic [BW-1:0]             bin;
  logic [CW-1:0]             phase;
  logic [SW-1:0]             sym_cnt;
  logic [PW-1:0]             p_reg;
  logic [PW-1:0]             rem;
  logic [QW-2:0]             quo;
  logic                      v1, v2, l1, l2;
  logic [PW:0]               rem_sh;
  logic                      ge;
  logic [QW-1:0]             q_fin;
  logic [PW-1:0]             p_next;
  logic                      acc, fin;

  function automatic logic signed [AW-1:0] sx(input logic signed [IN_W-1:0] v);
    return AW'(v);
  endfunction

  function automatic logic [OUT_W-1:0] scale(input logic signed [MW-1:0] m);
`ifdef ZFEQ_SAT_EN
    logic signed [MW-1:0] s;
    s = m >>> SH;
    return s > SMAX ? OUT_W'(SMAX) : s < SMIN ? OUT_W'(SMIN) : OUT_W'(s);
`else
    return OUT_W'(m >>> SH);
`endif
  endfunction

  // Restoring division of 2^(QW-1) by P: the numerator's single set bit enters on the first step.
  always_comb begin
    rem_sh = {rem, phase == CW'(1)};
    ge = rem_sh >= {1'b0, p_reg};
    q_fin = {quo, ge};
    p_next = $unsigned(sx(h_re[bin]) * sx(h_re[bin]) + sx(h_im[bin]) * sx(h_im[bin]));
  end

  assign acc = data_valid_i && eq_ready_o;
  assign fin = acc && sym_cnt == SW'(NSYM-1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      bin <= '0;
      phase <= '0;
      sym_cnt <= '0;
      p_reg <= '0;
      rem <= '0;
      quo <= '0;
      {v1, v2, l1, l2} <= '0;
      eq_ready_o <= 1'b0;
      eq_re_o <= '0;
      eq_im_o <= '0;
      eq_valid_o <= '0;
      eq_last_o <= 1'b0;
      err_drop_o <= 1'b0;
      for (int b = 0; b < NFFT; b++) begin
        h_re[b] <= '0;
        h_im[b] <= '0;
        recip[b] <= '0;
        a_re[b] <= '0;
        a_im[b] <= '0;
        m_re[b] <= '0;
        m_im[b] <= '0;
      end
    end else begin
      err_drop_o <= data_valid_i && !eq_ready_o;
      eq_ready_o <= state == READY && !chan_valid_i && !fin;
      v1 <= acc;
      l1 <= fin;
      v2 <= v1;
      l2 <= l1;
      eq_last_o <= l2;
      // Stage 1 uses the H registers as they stand before any same-cycle capture.
      for (int b = 0; b < NFFT; b++) begin
        a_re[b] <= sx(data_re_i[b*IN_W +: IN_W]) * sx(h_re[b]) + sx(data_im_i[b*IN_W +: IN_W]) * sx(h_im[b]);
        a_im[b] <= sx(data_im_i[b*IN_W +: IN_W]) * sx(h_re[b]) - sx(data_re_i[b*IN_W +: IN_W]) * sx(h_im[b]);
        m_re[b] <= MW'(a_re[b]) * $signed({{(MW-RECIP_W){1'b0}}, recip[b]});
        m_im[b] <= MW'(a_im[b]) * $signed({{(MW-RECIP_W){1'b0}}, recip[b]});
        eq_valid_o[b] <= v2 && !NULL_MASK[b];
        eq_re_o[b*OUT_W +: OUT_W] <= v2 && !NULL_MASK[b] ? scale(m_re[b]) : '0;
        eq_im_o[b*OUT_W +: OUT_W] <= v2 && !NULL_MASK[b] ? scale(m_im[b]) : '0;
      end
      if (acc) sym_cnt <= fin ? '0 : sym_cnt + SW'(1);
      if (chan_valid_i) begin
        for (int b = 0; b < NFFT; b++) begin
          h_re[b] <= chan_re_i[b*IN_W +: IN_W];
          h_im[b] <= chan_im_i[b*IN_W +: IN_W];
        end
        bin <= '0;
        phase <= '0;
        sym_cnt <= '0;
        state <= DIVIDE;
      end else if (state == DIVIDE) begin
        if (phase == '0) begin
          p_reg <= p_next;
          rem <= '0;
          quo <= '0;
          phase <= CW'(1);
        end else begin
          rem <= PW'(ge ? rem_sh - {1'b0, p_reg} : rem_sh);
          quo <= q_fin[QW-2:0];
          if (phase == CW'(QW)) begin
            recip[bin] <= |q_fin[QW-1:RECIP_W] ? '1 : q_fin[RECIP_W-1:0];
            phase <= '0;
            bin <= bin + BW'(1);
            if (bin == BW'(NFFT-1)) state <= READY;
          end else begin
            phase <= phase + CW'(1);
          end
        end
      end else if (fin) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_zf_equalizer_seq.sv
// tb_zf_equalizer_seq: directed self-checking bench for zf_equalizer_seq.
`timescale 1ns/1ps
module tb_zf_equalizer_seq;
  localparam int NFFT = 64;
  localparam int IN_W = 22;
  localparam int OUT_W = 32;
  localparam logic [63:0] NULL_MASK = 64'h0000_003F_F800_0001;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [NFFT*IN_W-1:0] chan_re_i = '0;
  logic [NFFT*IN_W-1:0] chan_im_i = '0;
  logic [NFFT*IN_W-1:0] data_re_i = '0;
  logic [NFFT*IN_W-1:0] data_im_i = '0;
  logic chan_valid_i = 1'b0;
  logic data_valid_i = 1'b0;
  logic eq_ready_o;
  logic [NFFT*OUT_W-1:0] eq_re_o;
  logic [NFFT*OUT_W-1:0] eq_im_o;
  logic [NFFT-1:0] eq_valid_o;
  logic eq_last_o;
  logic err_drop_o;

  int n_asrt = 0;
  int n_fail = 0;
  logic [OUT_W-1:0] exp_re [NFFT];
  logic [OUT_W-1:0] exp_im [NFFT];
  logic seen;

  zf_equalizer_seq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .chan_re_i(chan_re_i), .chan_im_i(chan_im_i), .chan_valid_i(chan_valid_i),
    .data_re_i(data_re_i), .data_im_i(data_im_i), .data_valid_i(data_valid_i),
    .eq_ready_o(eq_ready_o), .eq_re_o(eq_re_o), .eq_im_o(eq_im_o),
    .eq_valid_o(eq_valid_o), .eq_last_o(eq_last_o), .err_drop_o(err_drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_chan(input logic [IN_W-1:0] re, input logic [IN_W-1:0] im);
    for (int b = 0; b < NFFT; b++) begin
      chan_re_i[b*IN_W +: IN_W] = re;
      chan_im_i[b*IN_W +: IN_W] = im;
    end
  endtask

  task automatic fill_data(input logic [IN_W-1:0] re, input logic [IN_W-1:0] im);
    for (int b = 0; b < NFFT; b++) begin
      data_re_i[b*IN_W +: IN_W] = re;
      data_im_i[b*IN_W +: IN_W] = im;
    end
  endtask

  task automatic fill_exp(input logic [OUT_W-1:0] re, input logic [OUT_W-1:0] im);
    for (int b = 0; b < NFFT; b++) begin
      exp_re[b] = re;
      exp_im[b] = im;
    end
  endtask

  task automatic chk_out(input string tag);
    chk($sformatf("%s_valid", tag), eq_valid_o, ~NULL_MASK);
    for (int b = 0; b < NFFT; b++) begin
      chk($sformatf("%s_re%0d", tag, b), eq_re_o[b*OUT_W +: OUT_W], NULL_MASK[b] ? 32'd0 : exp_re[b]);
      chk($sformatf("%s_im%0d", tag, b), eq_im_o[b*OUT_W +: OUT_W], NULL_MASK[b] ? 32'd0 : exp_im[b]);
    end
  endtask

  // Called just after a capture edge plus `elapsed` further edges.
  task automatic wait_ready(input string tag, input int elapsed);
    tick(3008 - elapsed);
    chk($sformatf("%s_ready_early", tag), eq_ready_o, 0);
    tick(1);
    chk($sformatf("%s_ready_rise", tag), eq_ready_o, 1);
  endtask

  task automatic load_chan(input string tag);
    chan_valid_i = 1'b1;
    tick(1);
    chan_valid_i = 1'b0;
    chk($sformatf("%s_ready_fall", tag), eq_ready_o, 0);
    wait_ready(tag, 0);
  endtask

  task automatic send_one(input string tag, input logic last);
    data_valid_i = 1'b1;
    tick(1);
    data_valid_i = 1'b0;
    chk($sformatf("%s_drop", tag), err_drop_o, 0);
    tick(1);
    chk($sformatf("%s_early", tag), eq_valid_o, 0);
    tick(1);
    chk_out(tag);
    chk($sformatf("%s_last", tag), eq_last_o, last);
    tick(1);
    chk($sformatf("%s_strobe", tag), eq_valid_o, 0);
  endtask

  initial begin
    tick(3);
    chk("rst_ready", eq_ready_o, 0);
    chk("rst_valid", eq_valid_o, 0);
    chk("rst_re", {63'd0, |eq_re_o}, 0);
    chk("rst_im", {63'd0, |eq_im_o}, 0);
    chk("rst_last", eq_last_o, 0);
    chk("rst_drop", err_drop_o, 0);
    rst_i = 1'b1;
    tick(1);

    // Symbol with no estimate loaded is dropped
    fill_data(22'd16384, 22'd0);
    data_valid_i = 1'b1;
    tick(1);
    data_valid_i = 1'b0;
    chk("idle_drop", err_drop_o, 1);
    tick(1);
    chk("idle_drop_pulse", err_drop_o, 0);
    chk("idle_no_valid1", eq_valid_o, 0);
    tick(1);
    chk("idle_no_valid2", eq_valid_o, 0);

    // Unity channel
    fill_chan(22'd32768, 22'd0);
    load_chan("unity");
    chk("unity_recip0", dut.recip[0], 64'd32768);
    fill_exp(32'h0200_0000, 32'd0);
    send_one("unity", 1'b0);

    // Estimate and symbol in the same cycle: symbol uses the old unity H
    fill_chan(22'd0, 22'd32768);
    chan_valid_i = 1'b1;
    data_valid_i = 1'b1;
    tick(1);
    chan_valid_i = 1'b0;
    data_valid_i = 1'b0;
    chk("swap_ready_fall", eq_ready_o, 0);
    tick(1);
    chk("swap_early", eq_valid_o, 0);
    tick(1);
    chk_out("swap_oldh");
    wait_ready("rot", 2);

    // Rotated channel
    fill_data(22'd0, 22'd16384);
    fill_exp(32'h0200_0000, 32'd0);
    send_one("rot", 1'b0);
    fill_data(22'd8192, 22'd16384);
    fill_exp(32'h0200_0000, 32'hFF00_0000);
    send_one("rot_mix", 1'b0);

    // Clamped reciprocals, zero channel, floor rounding, then 13 back-to-back symbols
    fill_chan(22'd32768, 22'd0);
    chan_re_i[5*IN_W +: IN_W] = 22'd1;
    chan_re_i[6*IN_W +: IN_W] = 22'd0;
    chan_re_i[8*IN_W +: IN_W] = 22'd49152;
    load_chan("sat");
    chk("recip5", dut.recip[5], 64'hFFFF_FFFF);
    chk("recip6", dut.recip[6], 64'hFFFF_FFFF);
    chk("recip7", dut.recip[7], 64'd32768);
    chk("recip8", dut.recip[8], 64'd14563);
    fill_data(22'd16384, 22'd0);
    data_re_i[5*IN_W +: IN_W] = 22'd2097151;
    data_re_i[8*IN_W +: IN_W] = 22'h3FFFFF;
    fill_exp(32'h0200_0000, 32'd0);
`ifdef ZFEQ_SAT_EN
    exp_re[5] = 32'h7FFF_FFFF;
`else
    exp_re[5] = 32'hFFFF_DFFC;
`endif
    exp_re[6] = 32'd0;
    exp_re[8] = 32'hFFFF_FAAA;
    data_valid_i = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      tick(1);
      if (n == 13) data_valid_i = 1'b0;
      chk($sformatf("pkt%0d_valid", n), eq_valid_o, (n >= 3 && n <= 14) ? ~NULL_MASK : 64'd0);
      chk($sformatf("pkt%0d_last", n), eq_last_o, n == 14);
      chk($sformatf("pkt%0d_ready", n), eq_ready_o, n < 12);
      chk($sformatf("pkt%0d_drop", n), err_drop_o, n == 13);
      if (n == 3 || n == 14) chk_out($sformatf("pkt%0d", n));
    end

    // Abort: a second estimate mid-DIVIDE restarts the division
    fill_chan(22'd32768, 22'd0);
    chan_valid_i = 1'b1;
    tick(1);
    chan_valid_i = 1'b0;
    tick(999);
    chan_valid_i = 1'b1;
    tick(1);
    chan_valid_i = 1'b0;
    tick(2009);
    chk("abort_first_ready", eq_ready_o, 0);
    wait_ready("abort", 2009);

    // Reset with a symbol in flight: no output
    fill_data(22'd16384, 22'd0);
    data_valid_i = 1'b1;
    tick(1);
    data_valid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("rstpipe_ready", eq_ready_o, 0);
    chk("rstpipe_valid", eq_valid_o, 0);
    tick(1);
    rst_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      seen = seen | (|eq_valid_o);
    end
    chk("rstpipe_no_output", seen, 0);

    // Reset mid-DIVIDE: reciprocals cleared and no ready without a new estimate
    fill_chan(22'd32768, 22'd0);
    chan_valid_i = 1'b1;
    tick(1);
    chan_valid_i = 1'b0;
    tick(500);
    chk("rstdiv_recip0_before", dut.recip[0], 64'd32768);
    rst_i = 1'b0;
    #1;
    chk("rstdiv_recip0", dut.recip[0], 0);
    chk("rstdiv_ready", eq_ready_o, 0);
    chk("rstdiv_re", {63'd0, |eq_re_o}, 0);
    tick(1);
    rst_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3100; i++) begin
      tick(1);
      seen = seen | eq_ready_o;
    end
    chk("rstdiv_no_ready", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
